writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_if.sv | 41 ++++
 rtl/writeback_queue.sv | 94 +++++++++
 2 files changed

// File: rtl/writeback_queue_if.sv
// Bus bundle for the writeback queue: producer handshake, register-file
// write port, decode-stage bypass lookups and occupancy status.
interface writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [DW-1:0] in_data;
    logic          drain_hold;

    logic          reg_write_sig;
    logic [4:0]    write_reg;
    logic [DW-1:0] write_data;

    logic [4:0]    byp_addr1;
    logic [4:0]    byp_addr2;
    logic          byp_hit1;
    logic          byp_hit2;
    logic [DW-1:0] byp_data1;
    logic [DW-1:0] byp_data2;

    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output in_valid, in_reg, in_data, drain_hold, byp_addr1, byp_addr2,
        input  in_ready, reg_write_sig, write_reg, write_data,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2, count, full, empty
    );

    modport slave (
        input  in_valid, in_reg, in_data, drain_hold, byp_addr1, byp_addr2,
        output in_ready, reg_write_sig, write_reg, write_data,
        output byp_hit1, byp_hit2, byp_data1, byp_data2, count, full, empty
    );
endinterface

// File: rtl/writeback_queue.sv
// Circular writeback FIFO feeding the register file, with two combinational
// bypass ports that return the youngest pending value for a register.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic           CLK,
    input  logic           RST_N,
    writeback_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_mem_reg  [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_drain;
    logic [AW-1:0] w_idx  [DEPTH];
    logic          w_live [DEPTH];
    logic          w_hit1;
    logic          w_hit2;
    logic [DW-1:0] w_bdata1;
    logic [DW-1:0] w_bdata2;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // $0 writes complete the handshake but are never stored
    assign w_push  = bus.in_valid && !w_full && (bus.in_reg != 5'd0);
    assign w_drain = !w_empty && !bus.drain_hold;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem_reg[r_tail]  <= bus.in_reg;
                r_mem_data[r_tail] <= bus.in_data;
                r_tail             <= r_tail + AW'(1);
            end
            if (w_drain) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        w_hit1   = 1'b0;
        w_hit2   = 1'b0;
        w_bdata1 = '0;
        w_bdata2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx[i]  = r_head + AW'(i);
            w_live[i] = (CW'(i) < r_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i] && (bus.byp_addr1 != 5'd0) &&
                (r_mem_reg[w_idx[i]] == bus.byp_addr1)) begin
                w_hit1   = 1'b1;
                w_bdata1 = r_mem_data[w_idx[i]];
            end
            if (w_live[i] && (bus.byp_addr2 != 5'd0) &&
                (r_mem_reg[w_idx[i]] == bus.byp_addr2)) begin
                w_hit2   = 1'b1;
                w_bdata2 = r_mem_data[w_idx[i]];
            end
        end
    end

    assign bus.in_ready      = !w_full;
    assign bus.reg_write_sig = w_drain;
    assign bus.write_reg     = w_empty ? 5'd0 : r_mem_reg[r_head];
    assign bus.write_data    = w_empty ? '0   : r_mem_data[r_head];
    assign bus.byp_hit1      = w_hit1;
    assign bus.byp_hit2      = w_hit2;
    assign bus.byp_data1     = w_bdata1;
    assign bus.byp_data2     = w_bdata2;
    assign bus.count         = r_count;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
endmodule
